// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: opcode/flags/enable in, control word and step status out
interface micro_sequencer_if #(parameter int STEPS = 5);
    logic step_en;
    logic [3:0] opcode;
    logic flag_c;
    logic flag_z;
    logic [15:0] ctrl;
    logic [$clog2(STEPS)-1:0] step;
    logic last_step;
    logic halted;
    modport master(output step_en, opcode, flag_c, flag_z, input ctrl, step, last_step, halted);
    modport slave(input step_en, opcode, flag_c, flag_z, output ctrl, step, last_step, halted);
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: T-state microcode sequencer driving the 16-bit datapath control word
module micro_sequencer #(
    parameter int STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input logic CLK,
    input logic rst,
    micro_sequencer_if.slave bus
);
    localparam int SW = $clog2(STEPS);
    typedef enum logic {RUN, HALT} mode_t;
    mode_t mode_q, mode_d;
    logic [SW-1:0] step_q, step_d;
    logic [3:0] s, op, len;
    logic [15:0] exec;
    logic last;
    assign s = 4'(step_q);
    assign op = bus.opcode;
    assign len = !EARLY_END ? 4'(STEPS) :
                 (op == 4'h2 || op == 4'h3) ? 4'd5 :
                 (op == 4'h1 || op == 4'h4) ? 4'd4 : 4'd3;
    assign last = mode_q == RUN && s == len - 4'd1;
    // execute-phase microcode; any step past an opcode's table decodes to 0
    always_comb begin
        exec = '0;
        case (op)
            4'h1: exec = s == 4'd2 ? 16'h2400 : s == 4'd3 ? 16'h0900 : '0;
            4'h2, 4'h3: exec = s == 4'd2 ? 16'h2400 : s == 4'd3 ? 16'h0810 :
                               s == 4'd4 ? (op[0] ? 16'h8160 : 16'h8140) : '0;
            4'h4: exec = s == 4'd2 ? 16'h2400 : s == 4'd3 ? 16'h1080 : '0;
            4'h5: exec = s == 4'd2 ? 16'h0088 : '0;
            4'h6: exec = s == 4'd2 ? 16'h0401 : '0;
            4'h7: exec = s == 4'd2 ? 16'h0500 : '0;
            4'h8: exec = s == 4'd2 && bus.flag_c ? 16'h0401 : '0;
            4'h9: exec = s == 4'd2 && bus.flag_z ? 16'h0401 : '0;
            4'hF: exec = s == 4'd2 ? 16'h4000 : '0;
            default: exec = '0;
        endcase
    end
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (bus.step_en && mode_q == RUN) begin
            if (s == 4'd2 && op == 4'hF) mode_d = HALT;
            else step_d = last ? '0 : step_q + SW'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            mode_q <= RUN;
            step_q <= '0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end
    assign bus.ctrl = mode_q == HALT ? 16'h4000 : s == 4'd0 ? 16'h2002 : s == 4'd1 ? 16'h0A04 : exec;
    assign bus.step = step_q;
    assign bus.last_step = last;
    assign bus.halted = mode_q == HALT;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: three configurations checked against a table-driven reference model
module tb_micro_sequencer;
    logic CLK = 1'b0;
    logic rst = 1'b1;
    logic step_en = 1'b0;
    logic flag_c = 1'b0;
    logic flag_z = 1'b0;
    logic [3:0] op [3];
    logic [15:0] o_ctrl [3];
    logic [2:0] o_step [3];
    logic o_last [3];
    logic o_halt [3];
    int vectors = 0;
    int miscompares = 0;
    always #5 CLK = ~CLK;

    micro_sequencer_if #(.STEPS(5)) ifa();
    micro_sequencer_if #(.STEPS(6)) ifb();
    micro_sequencer_if #(.STEPS(6)) ifc();
    assign ifa.step_en = step_en;
    assign ifb.step_en = step_en;
    assign ifc.step_en = step_en;
    assign ifa.flag_c = flag_c;
    assign ifb.flag_c = flag_c;
    assign ifc.flag_c = flag_c;
    assign ifa.flag_z = flag_z;
    assign ifb.flag_z = flag_z;
    assign ifc.flag_z = flag_z;
    assign ifa.opcode = op[0];
    assign ifb.opcode = op[1];
    assign ifc.opcode = op[2];
    assign o_ctrl[0] = ifa.ctrl;
    assign o_ctrl[1] = ifb.ctrl;
    assign o_ctrl[2] = ifc.ctrl;
    assign o_step[0] = ifa.step;
    assign o_step[1] = ifb.step;
    assign o_step[2] = ifc.step;
    assign o_last[0] = ifa.last_step;
    assign o_last[1] = ifb.last_step;
    assign o_last[2] = ifc.last_step;
    assign o_halt[0] = ifa.halted;
    assign o_halt[1] = ifb.halted;
    assign o_halt[2] = ifc.halted;

    micro_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut_a(.CLK(CLK), .rst(rst), .bus(ifa.slave));
    micro_sequencer #(.STEPS(6), .EARLY_END(1'b1)) dut_b(.CLK(CLK), .rst(rst), .bus(ifb.slave));
    micro_sequencer #(.STEPS(6), .EARLY_END(1'b0)) dut_c(.CLK(CLK), .rst(rst), .bus(ifc.slave));

    logic [15:0] ucode [16][8];
    int ilen [16];
    int n_steps [3] = '{5, 6, 6};
    bit early [3] = '{1'b1, 1'b1, 1'b0};
    int m_step [3];
    bit m_halt [3];
    logic [15:0] lda_seq [5];

    function automatic int len_of(int i);
        return early[i] ? ilen[op[i]] : n_steps[i];
    endfunction

    function automatic logic [15:0] exp_ctrl(int i);
        if (m_halt[i]) return 16'h4000;
        if (m_step[i] == 0) return 16'h2002;
        if (m_step[i] == 1) return 16'h0A04;
        if ((op[i] == 4'h8 && !flag_c) || (op[i] == 4'h9 && !flag_z)) return 16'h0000;
        return ucode[op[i]][m_step[i]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // compare all DUTs to the model mid-cycle, then advance the model with the same inputs the edge sees
    task automatic tick();
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ctrl[%0d]", i), 32'(o_ctrl[i]), 32'(exp_ctrl(i)));
            chk($sformatf("step[%0d]", i), 32'(o_step[i]), 32'(m_step[i]));
            chk($sformatf("last[%0d]", i), 32'(o_last[i]), 32'(!m_halt[i] && m_step[i] == len_of(i) - 1));
            chk($sformatf("halt[%0d]", i), 32'(o_halt[i]), 32'(m_halt[i]));
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_step[i] = 0;
                m_halt[i] = 1'b0;
            end else if (step_en && !m_halt[i]) begin
                if (m_step[i] == 2 && op[i] == 4'hF) m_halt[i] = 1'b1;
                else if (m_step[i] == len_of(i) - 1) m_step[i] = 0;
                else m_step[i]++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic restart(input logic [3:0] o);
        for (int i = 0; i < 3; i++) op[i] = o;
        rst = 1'b1;
        step_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            ilen[a] = 3;
            for (int b = 0; b < 8; b++) ucode[a][b] = 16'h0000;
        end
        ilen[1] = 4; ilen[2] = 5; ilen[3] = 5; ilen[4] = 4;
        ucode[1][2] = 16'h2400; ucode[1][3] = 16'h0900;
        ucode[2][2] = 16'h2400; ucode[2][3] = 16'h0810; ucode[2][4] = 16'h8140;
        ucode[3][2] = 16'h2400; ucode[3][3] = 16'h0810; ucode[3][4] = 16'h8160;
        ucode[4][2] = 16'h2400; ucode[4][3] = 16'h1080;
        ucode[5][2] = 16'h0088; ucode[6][2] = 16'h0401; ucode[7][2] = 16'h0500;
        ucode[8][2] = 16'h0401; ucode[9][2] = 16'h0401; ucode[15][2] = 16'h4000;
        lda_seq = '{16'h2002, 16'h0A04, 16'h2400, 16'h0900, 16'h2002};
        for (int i = 0; i < 3; i++) begin
            m_step[i] = 0;
            m_halt[i] = 1'b0;
        end

        restart(4'h1);
        chk("reset_ctrl", 32'(o_ctrl[0]), 32'h2002);
        chk("reset_last", 32'(o_last[0]), 32'h0);
        for (int t = 0; t < 5; t++) begin
            chk("lda_ctrl", 32'(o_ctrl[0]), 32'(lda_seq[t]));
            chk("lda_last", 32'(o_last[0]), 32'(t == 3));
            tick();
        end

        restart(4'h2);
        repeat (4) tick();
        chk("add_t4_ee1", 32'(o_ctrl[1]), 32'h8140);
        chk("add_last_ee1", 32'(o_last[1]), 32'h1);
        chk("add_last_ee0", 32'(o_last[2]), 32'h0);
        tick();
        chk("add_wrap_ee1", 32'(o_step[1]), 32'h0);
        chk("add_t5_ee0", 32'(o_ctrl[2]), 32'h0000);
        chk("add_t5_last_ee0", 32'(o_last[2]), 32'h1);
        for (int i = 0; i < 3; i++) op[i] = 4'h3;
        tick();
        chk("add_wrap_ee0", 32'(o_step[2]), 32'h0);
        repeat (3) tick();
        chk("sub_t4_ee1", 32'(o_ctrl[1]), 32'h8160);

        restart(4'h8);
        flag_c = 1'b0;
        flag_z = 1'b1;
        repeat (2) tick();
        chk("jc_not_taken", 32'(o_ctrl[0]), 32'h0000);
        flag_c = 1'b1;
        #1;
        chk("jc_taken", 32'(o_ctrl[0]), 32'h0401);
        tick();
        chk("jc_len", 32'(o_step[0]), 32'h0);
        restart(4'h9);
        repeat (2) tick();
        chk("jz_taken", 32'(o_ctrl[0]), 32'h0401);
        flag_z = 1'b0;
        #1;
        chk("jz_not_taken", 32'(o_ctrl[0]), 32'h0000);
        tick();
        chk("jz_len", 32'(o_step[0]), 32'h0);

        restart(4'hF);
        repeat (2) tick();
        chk("hlt_t2", 32'(o_ctrl[0]), 32'h4000);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("hlt_halted", 32'(o_halt[0]), 32'h1);
            chk("hlt_step", 32'(o_step[0]), 32'h2);
            chk("hlt_ctrl", 32'(o_ctrl[0]), 32'h4000);
            tick();
        end
        restart(4'h0);
        chk("hlt_rst_step", 32'(o_step[0]), 32'h0);
        chk("hlt_rst_halt", 32'(o_halt[0]), 32'h0);
        chk("hlt_rst_ctrl", 32'(o_ctrl[0]), 32'h2002);

        restart(4'h2);
        repeat (3) tick();
        step_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_step", 32'(o_step[0]), 32'h3);
            chk("hold_ctrl", 32'(o_ctrl[0]), 32'h0810);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst", 32'(o_step[0]), 32'h0);
        step_en = 1'b1;

        restart(4'hC);
        repeat (2) tick();
        chk("undef_t2", 32'(o_ctrl[0]), 32'h0000);
        chk("undef_last", 32'(o_last[0]), 32'h1);
        tick();
        chk("undef_wrap", 32'(o_step[0]), 32'h0);

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++)
                if (m_step[i] == 0 && !m_halt[i]) op[i] = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom);
            flag_z = 1'($urandom);
            step_en = ($urandom % 4) != 0;
            rst = ($urandom % 64) == 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microcode control sequencer for the 8-bit bus CPU. It steps through T-states for the current instruction-register opcode and drives the 16-bit control word to the datapath: PC, MAR, RAM, A/B registers, ALU, output register and flags register. Compared with the fixed five-stage controller, it adds:
- a configurable step count;
- optional early instruction termination;
- carry/zero conditional jumps;
- flags-register load;
- a latched halt;
- a clock-enable input instead of a gated clock.

## Interface
- STEPS, 5, maximum T-states per instruction; legal range 5..8.
- EARLY_END, 1, 1 = wrap to T0 after an instruction's last defined step; 0 = always run STEPS steps.
- CLK  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- step_en  input  1  advance enable; step and halted change only when high (rst excepted).
- opcode  input  4  IR[7:4]; valid from T2 onward.
- flag_c  input  1  registered carry flag.
- flag_z  input  1  registered zero flag.
- ctrl  output  16  control word; bits: j0 co1 ce2 oi3 bi4 su5 so6 ao7 ai8 ii9 io10 ro11 ri12 mi13 hlt14 fi15.
- step  output  $clog2(STEPS)  current T-state.
- last_step  output  1  high while step is the final step of the current instruction.
- halted  output  1  latched halt.

## Operation
- State: step counter and halted flag only.
- ctrl is a combinational decode of (step, opcode, flag_c, flag_z, halted).
- Fetch, for all opcodes:
  - T0: mi|co = 0x2002.
  - T1: ro|ii|ce = 0x0A04.
- Execute, T2 onward:
  - NOP 0000: T2 = 0.
  - LDA 0001: T2 = mi|io 0x2400; T3 = ro|ai 0x0900.
  - ADD 0010: T2 = 0x2400; T3 = ro|bi 0x0810; T4 = so|ai|fi 0x8140.
  - SUB 0011: as ADD, but T4 = so|su|ai|fi 0x8160.
  - STA 0100: T2 = 0x2400; T3 = ao|ri 0x1080.
  - OUT 0101: T2 = ao|oi 0x0088.
  - JMP 0110: T2 = io|j 0x0401.
  - LDI 0111: T2 = io|ai 0x0500.
  - JC 1000: T2 = 0x0401 if flag_c, else 0.
  - JZ 1001: T2 = 0x0401 if flag_z, else 0.
  - HLT 1111: T2 = hlt 0x4000.
  - Undefined opcodes (1010–1110): treated as NOP.
- Instruction length L, with EARLY_END = 1:
  - 5 for ADD and SUB.
  - 4 for LDA and STA.
  - 3 for all others, including NOP, undefined opcodes and a not-taken JC/JZ.
- Instruction length with EARLY_END = 0: L = STEPS for every opcode. Steps beyond the defined table decode to ctrl = 0.
- Step advance, on each posedge with step_en = 1 and halted = 0:
  - step = L-1 → step wraps to 0.
  - Otherwise step increments by 1.
- last_step = (step == L-1), combinational.
- Halt:
  - A posedge with step_en = 1, step = 2 and opcode = HLT sets halted and leaves step at 2.
  - While halted: step is frozen, ctrl = 0x4000 and last_step = 0.
  - Only rst clears halted.
- Flags are sampled combinationally during T2. The flags register must not change during T2; it is written only by fi at T4.

## Timing
- Reset values: step = 0, halted = 0, so ctrl = 0x2002 and last_step = 0.
- rst has priority over step_en and halted. Asserting rst at any step forces step = 0 and halted = 0 at the next edge.
- step_en = 0: step, halted and ctrl hold, provided opcode and flags are stable.
- The datapath samples the bus on the same posedge that advances step. ctrl is stable for the whole cycle preceding that edge.
- The IR loads at the T1→T2 edge, so opcode decode is valid from T2. The fetch steps ignore opcode.
- Instruction throughput: L enabled cycles. Zero-cycle gap between instructions: T0 of the next instruction follows the last step directly.

## Test plan
- Reset, opcode = LDA, step_en = 1, EARLY_END = 1:
  - ctrl sequence 0x2002, 0x0A04, 0x2400, 0x0900, then 0x2002.
  - last_step high only at step 3.
- ADD then SUB with STEPS = 6:
  - EARLY_END = 1: T4 = 0x8140 then 0x8160, wrap after step 4.
  - EARLY_END = 0: steps 0..5, with step 5 = 0x0000 and wrap after step 5.
- JC and JZ at T2, with flag_c/flag_z = 0 → ctrl 0x0000, = 1 → 0x0401. Instruction length is 3 in both cases.
- HLT:
  - At T2, ctrl = 0x4000.
  - From the next edge, halted = 1; step stays 2 and ctrl stays 0x4000 for 10 cycles with step_en = 1.
  - rst for one cycle: step = 0, halted = 0, ctrl = 0x2002.
- step_en held low for 3 cycles at ADD T3: step and ctrl (0x0810) are unchanged. rst asserted there with step_en = 0: the next edge gives step = 0.
- Undefined opcode 1100: T2 = 0x0000, and with EARLY_END = 1 the sequencer wraps after step 2.
